// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_ctrl
// Brief    : Instruction fetch controller with BOOT/RUN/HALT sequencing, a
//            2-entry in-order {instr, pc} buffer toward decode and redirects.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    output logic        imem_en,
    input  logic [31:0] imem_instr,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [31:0] C_WORD_MASK = 32'hFFFF_FFFC;
    localparam logic [1:0]  C_CNT_FULL  = 2'd2;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [1:0]  r_cnt;
    logic [31:0] r_instr0;
    logic [31:0] r_instr1;
    logic [31:0] r_epc0;
    logic [31:0] r_epc1;
    logic        w_pop;
    logic        w_fetch;

    assign id_valid = (r_cnt != 2'd0);
    assign w_pop    = id_valid & id_ready;
    assign imem_pc  = r_pc & C_WORD_MASK;
    assign imem_en  = w_fetch;
    assign id_instr = id_valid ? r_instr0 : 32'h0;
    assign id_pc    = id_valid ? r_epc0   : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A redirect freezes the RUN/HALT decision for its cycle; BOOT always exits.
    always_comb begin
        w_state_nxt = r_state;
        w_fetch     = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_nxt = halt ? HALT : RUN;
            end
            RUN: begin
                w_fetch = !halt && !redirect_valid && ((r_cnt != C_CNT_FULL) || w_pop);
                if (!redirect_valid && halt) begin
                    w_state_nxt = HALT;
                end
            end
            HALT: begin
                if (!redirect_valid && !halt) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc & C_WORD_MASK;
        end else if (w_fetch) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    // Entry 0 is always the head; entry 1 shifts down on a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= 2'd0;
            r_instr0 <= 32'h0;
            r_instr1 <= 32'h0;
            r_epc0   <= 32'h0;
            r_epc1   <= 32'h0;
        end else if (redirect_valid) begin
            r_cnt <= 2'd0;
        end else begin
            case ({w_fetch, w_pop})
                2'b01: begin
                    r_instr0 <= r_instr1;
                    r_epc0   <= r_epc1;
                    r_cnt    <= r_cnt - 2'd1;
                end
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_instr0 <= imem_instr;
                        r_epc0   <= imem_pc;
                    end else begin
                        r_instr1 <= imem_instr;
                        r_epc1   <= imem_pc;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_instr0 <= imem_instr;
                        r_epc0   <= imem_pc;
                    end else begin
                        r_instr0 <= r_instr1;
                        r_epc0   <= r_epc1;
                        r_instr1 <= imem_instr;
                        r_epc1   <= imem_pc;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_ctrl
// Brief    : Scoreboard bench for instr_fetch_ctrl with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_ctrl;

    localparam logic [31:0] C_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] C_RESET_PC2 = 32'hFFFF_FFF8;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst2_n = 1'b0;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b0;
    logic [31:0] imem_pc, imem_instr, id_instr, id_pc;
    logic        imem_en, id_valid;
    logic [31:0] imem_pc2, imem_instr2, id_instr2, id_pc2;
    logic        imem_en2, id_valid2;

    logic [31:0] rom [16];

    assign imem_instr  = imem_en  ? rom[imem_pc[5:2]]  : 32'h0;
    assign imem_instr2 = imem_en2 ? rom[imem_pc2[5:2]] : 32'h0;

    always #5 clk = ~clk;

    instr_fetch_ctrl #(.RESET_PC(C_RESET_PC), .PC_STEP(32'd4)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_en(imem_en),
        .imem_instr(imem_instr), .halt(halt), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc)
    );

    instr_fetch_ctrl #(.RESET_PC(C_RESET_PC2), .PC_STEP(32'd4)) u_dut_wrap (
        .clk(clk), .rst_n(rst2_n), .imem_pc(imem_pc2), .imem_en(imem_en2),
        .imem_instr(imem_instr2), .halt(1'b0), .redirect_valid(1'b0),
        .redirect_pc(32'h0), .id_valid(id_valid2), .id_ready(1'b1),
        .id_instr(id_instr2), .id_pc(id_pc2)
    );

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    ent_t exp_q[$];

    // Reference model: occupancy, next fetch address and run/halt mode.
    bit          m_boot, m_halted;
    int          m_cnt;
    logic [31:0] m_pc;
    logic        exp_en;
    logic [31:0] exp_pc;
    bit          p_valid, p_rv, p_pop, p_fetch, p_h;
    logic [31:0] p_rpc;
    ent_t        p_ent;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_boot   = 1'b1;
        m_halted = 1'b0;
        m_cnt    = 0;
        m_pc     = C_RESET_PC;
        exp_en   = 1'b0;
        exp_pc   = C_RESET_PC;
        p_valid  = 1'b0;
    endtask

    task automatic apply_pending();
        if (p_valid) begin
            if (p_rv) begin
                exp_q.delete();
                m_cnt = 0;
                m_pc  = p_rpc;
            end else begin
                m_cnt = m_cnt - (p_pop ? 1 : 0) + (p_fetch ? 1 : 0);
                if (p_fetch) begin
                    exp_q.push_back(p_ent);
                    m_pc = m_pc + 32'd4;
                end
            end
            if (m_boot) begin
                m_boot   = 1'b0;
                m_halted = p_h;
            end else if (!p_rv) begin
                m_halted = p_h;
            end
        end
    endtask

    task automatic drive(input bit h, input bit rv, input logic [31:0] rpc, input bit rdy);
        bit active;
        halt           = h;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        active  = !m_boot && !m_halted;
        p_pop   = (m_cnt > 0) && rdy;
        p_fetch = active && !h && !rv && ((m_cnt < 2) || p_pop);
        p_rv    = rv;
        p_rpc   = {rpc[31:2], 2'b00};
        p_h     = h;
        p_ent   = '{instr: rom[m_pc[5:2]], pc: m_pc};
        p_valid = 1'b1;
        exp_en  = p_fetch;
        exp_pc  = m_pc;
    endtask

    task automatic step(input bit h, input bit rv, input logic [31:0] rpc, input bit rdy);
        @(posedge clk);
        #1;
        apply_pending();
        drive(h, rv, rpc, rdy);
    endtask

    task automatic reset_seq(input bit rdy);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'h0, rdy);
        mon_en = 1'b1;
    endtask

    // Monitor: compares whatever the DUT presents against the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("imem_en", {31'b0, imem_en}, {31'b0, exp_en});
                chk("imem_pc", imem_pc, exp_pc);
                chk("id_valid", {31'b0, id_valid}, (exp_q.size() > 0) ? 32'd1 : 32'd0);
                if (id_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_entry actual_pc=%h expected=none", id_pc);
                    end else begin
                        chk("id_instr", id_instr, exp_q[0].instr);
                        chk("id_pc", id_pc, exp_q[0].pc);
                        if (id_ready) void'(exp_q.pop_front());
                    end
                end else begin
                    chk("id_instr_zero", id_instr, 32'h0);
                    chk("id_pc_zero", id_pc, 32'h0);
                end
            end
        end
    end

    logic [31:0] wrap_exp [3];
    int          n_wrap;

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = $urandom;
        rom[0] = 32'h0022_1820;
        model_reset();

        #2;
        chk("rst_imem_en", {31'b0, imem_en}, 32'd0);
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_imem_pc", imem_pc, C_RESET_PC);

        // Wrap-around fetch addresses from a high reset PC.
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        n_wrap = 0;
        @(posedge clk);
        #1;
        rst2_n = 1'b1;
        for (int c = 0; c < 10 && n_wrap < 3; c++) begin
            @(negedge clk);
            if (n_wrap == 1) begin
                chk("wrap_id_valid", {31'b0, id_valid2}, 32'd1);
                chk("wrap_id_pc", id_pc2, 32'hFFFF_FFF8);
                chk("wrap_id_instr", id_instr2, rom[14]);
            end
            if (imem_en2 === 1'b1) begin
                chk("wrap_fetch_pc", imem_pc2, wrap_exp[n_wrap]);
                n_wrap++;
            end
        end
        if (n_wrap < 3) begin
            checks++;
            errors++;
            $display("FAIL wrap_timeout actual_fetches=%0d expected=3", n_wrap);
        end

        // Free-flowing decode from reset.
        reset_seq(1'b1);
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Decode stalled from reset, then released.
        reset_seq(1'b0);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect to an unaligned target with a full buffer.
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_003E, 1'b1);
        repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Halt with a full buffer drains it, then fetch resumes.
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0010, 1'b1);
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Fill to two entries at pc 0x20, then assert reset between edges.
        step(1'b0, 1'b1, 32'h0000_0018, 1'b0);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("async_id_valid", {31'b0, id_valid}, 32'd0);
        chk("async_imem_pc", imem_pc, C_RESET_PC);
        chk("async_imem_en", {31'b0, imem_en}, 32'd0);
        chk("async_id_instr", id_instr, 32'h0);
        chk("async_id_pc", id_pc, 32'h0);
        reset_seq(1'b1);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Randomised traffic.
        begin
            bit          h;
            bit          rv;
            logic [31:0] rpc;
            h = 1'b0;
            for (int c = 0; c < 1500; c++) begin
                if ($urandom_range(99) < 12) h = ~h;
                rv  = ($urandom_range(99) < 8);
                rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(15)) : $urandom;
                if ($urandom_range(299) == 0) begin
                    reset_seq($urandom_range(1) == 1);
                end else begin
                    step(h, rv, rpc, $urandom_range(99) < 65);
                end
            end
        end

        @(posedge clk);
        #1;
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
